// File: rtl/uart_ip_pkg.sv
// Shared definitions for the UART receive IP: baud table, field encodings,
// receiver state enum and small arithmetic/parity helpers.
package uart_ip_pkg;

    // Supported line rates, indexed by the 4-bit baud select (index 7 = 9600)
    localparam logic [31:0] BAUD_RATES [16] = '{
        32'd200,    32'd300,    32'd600,    32'd1200,
        32'd1800,   32'd2400,   32'd4800,   32'd9600,
        32'd14400,  32'd19200,  32'd28800,  32'd38400,
        32'd57600,  32'd115200, 32'd230400, 32'd460800
    };

    typedef enum logic [1:0] {
        FRAME_5 = 2'b00,
        FRAME_6 = 2'b01,
        FRAME_7 = 2'b10,
        FRAME_8 = 2'b11
    } frame_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic {
        STOP_ONE = 1'b0,
        STOP_TWO = 1'b1
    } stop_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_e;

    // Clocks per oversample tick, floored, never below one
    function automatic logic [31:0] calc_div(input logic [31:0] clk_hz,
                                             input logic [31:0] os,
                                             input logic [31:0] baud);
        logic [31:0] d;
        d = clk_hz / (os * baud);
        if (d == 32'd0) begin
            return 32'd1;
        end else begin
            return d;
        end
    endfunction

    // Even parity of a data word (1 when an odd number of bits are set)
    function automatic logic parity_of(input logic [7:0] d);
        return ^d;
    endfunction

    // Index of the last data bit for a frame length encoding
    function automatic logic [2:0] last_bit_idx(input frame_e f);
        case (f)
            FRAME_5: return 3'd4;
            FRAME_6: return 3'd5;
            FRAME_7: return 3'd6;
            FRAME_8: return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_ip_rx_if.sv
// Consumer-side handshake of the UART receiver: held word, status and pop.
interface uart_ip_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    // Receiver side drives the holding register, consumer side pops it
    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_ip_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, where DIV comes
// from a constant per-rate table. resync restarts the period so the receiver
// can phase-align to a start edge.
module uart_ip_baud_tick
    import uart_ip_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [3:0] baud_sel,
    input  logic       resync,
    output logic       tick
);

    logic [31:0] div_tab_s [16];
    logic [31:0] div_s;
    logic [31:0] cnt_r;
    logic        tick_r;

    for (genvar gi = 0; gi < 16; gi++) begin : g_div
        assign div_tab_s[gi] = calc_div(32'(CLK_FREQ_HZ), 32'(OVERSAMPLE), BAUD_RATES[gi]);
    end

    assign div_s = div_tab_s[baud_sel];

    // Prescaler counter with registered tick; resync restarts the period
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r  <= 32'd0;
            tick_r <= 1'b0;
        end else if (resync) begin
            cnt_r  <= 32'd0;
            tick_r <= 1'b0;
        end else if (cnt_r >= div_s - 32'd1) begin
            cnt_r  <= 32'd0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 32'd1;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_ip_rx.sv
// UART receiver: synchronizes the serial line, detects the start edge,
// samples each bit at its centre using oversample ticks, checks parity and
// stop bits, and delivers the word through a single-entry holding register.
module uart_ip_rx
    import uart_ip_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVERSAMPLE  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rx,
    input  logic              en,
    input  logic [1:0]        frame_sel,
    input  logic [1:0]        parity_sel,
    input  logic              stop_sel,
    input  logic [3:0]        baud_sel,
    output logic              busy,
    uart_ip_rx_if.master      rx_if
);

    localparam logic [7:0] HALF_M1 = 8'(OVERSAMPLE / 2 - 1);
    localparam logic [7:0] FULL_M1 = 8'(OVERSAMPLE - 1);

    // Line synchronizer and edge history
    logic       sync1_r, sync2_r, prev_r;
    logic       rx_s, fall_s;

    // Bit engine
    state_e     state_r, next_s;
    logic [7:0] tick_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       pe_r, fe_r;
    frame_e     frame_r;
    parity_e    parity_r;
    stop_e      stop_r;
    logic [3:0] baud_r;
    logic       busy_r;

    // Holding register
    logic [7:0] data_r;
    logic       valid_r, pe_hold_r, fe_hold_r, ovr_r;

    // Control strobes
    logic       tick_s, resync_s, start_s, complete_s, bit_tick_s;
    logic [7:0] limit_s;
    logic [2:0] last_bit_s;
    logic       par_en_s, par_x_s, parity_bad_s, stop_bad_s, word_fe_s;

    assign rx_s         = sync2_r;
    assign fall_s       = prev_r & ~sync2_r;
    assign resync_s     = (state_r == ST_IDLE) & fall_s;
    assign limit_s      = (state_r == ST_START) ? HALF_M1 : FULL_M1;
    assign bit_tick_s   = tick_s & (tick_cnt_r == limit_s);
    assign last_bit_s   = last_bit_idx(frame_r);
    assign par_en_s     = (parity_r == PAR_EVEN) | (parity_r == PAR_ODD);
    assign par_x_s      = parity_of(shift_r) ^ rx_s;
    assign parity_bad_s = (parity_r == PAR_ODD) ? ~par_x_s : par_x_s;
    assign stop_bad_s   = ~rx_s;
    assign word_fe_s    = fe_r | stop_bad_s;

    uart_ip_baud_tick #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_tick (
        .clk      (clk),
        .arst_n   (arst_n),
        .baud_sel (baud_r),
        .resync   (resync_s),
        .tick     (tick_s)
    );

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // FSM state register and registered busy flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != ST_IDLE);
        end
    end

    // Next-state logic; dropping en aborts any frame in progress
    always_comb begin
        next_s     = state_r;
        start_s    = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && fall_s) begin
                    next_s  = ST_START;
                    start_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!en) begin
                    next_s = ST_IDLE;
                end else if (bit_tick_s) begin
                    if (rx_s) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_DATA;
                    end
                end else begin
                    next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (!en) begin
                    next_s = ST_IDLE;
                end else if (bit_tick_s && (bit_cnt_r == last_bit_s)) begin
                    if (par_en_s) begin
                        next_s = ST_PARITY;
                    end else begin
                        next_s = ST_STOP1;
                    end
                end else begin
                    next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (!en) begin
                    next_s = ST_IDLE;
                end else if (bit_tick_s) begin
                    next_s = ST_STOP1;
                end else begin
                    next_s = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (!en) begin
                    next_s = ST_IDLE;
                end else if (bit_tick_s) begin
                    if (stop_r == STOP_TWO) begin
                        next_s = ST_STOP2;
                    end else begin
                        next_s     = ST_IDLE;
                        complete_s = 1'b1;
                    end
                end else begin
                    next_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (!en) begin
                    next_s = ST_IDLE;
                end else if (bit_tick_s) begin
                    next_s     = ST_IDLE;
                    complete_s = 1'b1;
                end else begin
                    next_s = ST_STOP2;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Bit engine: latch frame config at start, count ticks, shift and check bits
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tick_cnt_r <= 8'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            pe_r       <= 1'b0;
            fe_r       <= 1'b0;
            frame_r    <= FRAME_8;
            parity_r   <= PAR_NONE;
            stop_r     <= STOP_ONE;
            baud_r     <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            if (start_s) begin
                tick_cnt_r <= 8'd0;
                bit_cnt_r  <= 3'd0;
                shift_r    <= 8'd0;
                pe_r       <= 1'b0;
                fe_r       <= 1'b0;
                frame_r    <= frame_e'(frame_sel);
                parity_r   <= parity_e'(parity_sel);
                stop_r     <= stop_e'(stop_sel);
                baud_r     <= baud_sel;
            end
        end else if (tick_s) begin
            if (bit_tick_s) begin
                tick_cnt_r <= 8'd0;
                case (state_r)
                    ST_DATA: begin
                        shift_r[bit_cnt_r] <= rx_s;
                        bit_cnt_r          <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: pe_r <= parity_bad_s;
                    ST_STOP1:  fe_r <= fe_r | stop_bad_s;
                    default:   ;
                endcase
            end else begin
                tick_cnt_r <= tick_cnt_r + 8'd1;
            end
        end
    end

    // Holding register: load on completion, flag overrun when still full, pop on ack
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_r    <= 8'd0;
            valid_r   <= 1'b0;
            pe_hold_r <= 1'b0;
            fe_hold_r <= 1'b0;
            ovr_r     <= 1'b0;
        end else if (complete_s) begin
            if (!valid_r || rx_if.rx_ack) begin
                data_r    <= shift_r;
                valid_r   <= 1'b1;
                pe_hold_r <= pe_r;
                fe_hold_r <= word_fe_s;
                ovr_r     <= 1'b0;
            end else begin
                ovr_r <= 1'b1;
            end
        end else if (rx_if.rx_ack && valid_r) begin
            valid_r   <= 1'b0;
            pe_hold_r <= 1'b0;
            fe_hold_r <= 1'b0;
            ovr_r     <= 1'b0;
        end
    end

    assign busy              = busy_r;
    assign rx_if.rx_data     = data_r;
    assign rx_if.rx_valid    = valid_r;
    assign rx_if.parity_err  = pe_hold_r;
    assign rx_if.frame_err   = fe_hold_r;
    assign rx_if.overrun     = ovr_r;

endmodule

// File: tb/tb_uart_ip_rx.sv
// Directed bench for uart_ip_rx. The clock is scaled so one oversample tick
// is 4 clocks (614400 Hz / (16 * 9600)), giving a 64-clock bit period.
module tb_uart_ip_rx;
    import uart_ip_pkg::*;

    localparam int CLK_HZ = 614_400;
    localparam int BITCLK = 64;

    logic       clk;
    logic       arst_n;
    logic       rx;
    logic       en;
    logic [1:0] frame_sel;
    logic [1:0] parity_sel;
    logic       stop_sel;
    logic [3:0] baud_sel;
    logic       busy;

    int n_cmp;
    int n_err;

    uart_ip_rx_if u_if ();

    uart_ip_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .OVERSAMPLE  (16)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .rx         (rx),
        .en         (en),
        .frame_sel  (frame_sel),
        .parity_sel (parity_sel),
        .stop_sel   (stop_sel),
        .baud_sel   (baud_sel),
        .busy       (busy),
        .rx_if      (u_if)
    );

    // 100 MHz nominal bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one serial frame, LSB first, starting at the current negedge
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                              input bit par_bit, input int nstop, input bit stop2_val);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            repeat (BITCLK) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (BITCLK) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BITCLK) @(negedge clk);
        if (nstop == 2) begin
            rx = stop2_val;
            repeat (BITCLK) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Wait a bounded number of cycles for rx_valid; an expired bound is a failure
    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (u_if.rx_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(u_if.rx_valid), 32'd1);
    endtask

    task automatic pop();
        @(negedge clk);
        u_if.rx_ack = 1'b1;
        @(negedge clk);
        u_if.rx_ack = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        int n;
        n_cmp        = 0;
        n_err        = 0;
        arst_n       = 1'b0;
        rx           = 1'b1;
        en           = 1'b1;
        frame_sel    = 2'b11;
        parity_sel   = 2'b00;
        stop_sel     = 1'b0;
        baud_sel     = 4'd7;
        u_if.rx_ack  = 1'b0;

        // Reset state and package helpers
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(u_if.rx_valid), 32'd0);
        chk("rst_data", 32'(u_if.rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, u_if.parity_err, u_if.frame_err, u_if.overrun}, 32'd0);
        chk("div_100m_9600", calc_div(32'd100_000_000, 32'd16, 32'd9600), 32'd651);
        chk("div_floor_min", calc_div(32'd100, 32'd16, 32'd460800), 32'd1);
        chk("baud_tab_7", BAUD_RATES[7], 32'd9600);
        arst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5, with config changed mid-frame (must not affect this frame)
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (300) @(negedge clk);
                frame_sel  = 2'b00;
                parity_sel = 2'b01;
                repeat (260) @(negedge clk);
                chk("a5_not_early", 32'(u_if.rx_valid), 32'd0);
            end
        join
        wait_valid("a5_valid", 200);
        chk("a5_data", 32'(u_if.rx_data), 32'hA5);
        chk("a5_flags", {29'd0, u_if.parity_err, u_if.frame_err, u_if.overrun}, 32'd0);
        pop();
        chk("a5_ack_clears", 32'(u_if.rx_valid), 32'd0);
        pop();
        chk("ack_when_empty", 32'(u_if.rx_valid), 32'd0);

        // 5E1 0x15 with wrong parity bit: 0x15 has three ones, even parity bit is 1
        frame_sel  = 2'b00;
        parity_sel = 2'b01;
        send_frame(8'h15, 5, 1'b1, 1'b0, 1, 1'b1);
        wait_valid("p5e_valid", 200);
        chk("p5e_data", 32'(u_if.rx_data), 32'h15);
        chk("p5e_parity_err", 32'(u_if.parity_err), 32'd1);
        chk("p5e_frame_err", 32'(u_if.frame_err), 32'd0);
        pop();
        // 5O1 0x15 with correct odd parity bit 0
        parity_sel = 2'b10;
        send_frame(8'h15, 5, 1'b1, 1'b0, 1, 1'b1);
        wait_valid("p5o_valid", 200);
        chk("p5o_data", 32'(u_if.rx_data), 32'h15);
        chk("p5o_parity_err", 32'(u_if.parity_err), 32'd0);
        pop();

        // Glitch of 3/16 bit (12 clocks): start rejected, nothing delivered
        frame_sel  = 2'b11;
        parity_sel = 2'b00;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_rise", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_busy_fall", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(u_if.rx_valid), 32'd0);

        // 8N2 0x3C with second stop bit low
        stop_sel = 1'b1;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0);
        wait_valid("n2_valid", 200);
        chk("n2_data", 32'(u_if.rx_data), 32'h3C);
        chk("n2_frame_err", 32'(u_if.frame_err), 32'd1);
        pop();
        stop_sel = 1'b0;
        repeat (10) @(negedge clk);

        // Overrun: two frames without a pop keep the first word
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("ovr_data", 32'(u_if.rx_data), 32'h11);
        chk("ovr_flag", 32'(u_if.overrun), 32'd1);
        chk("ovr_valid", 32'(u_if.rx_valid), 32'd1);
        pop();
        chk("ovr_ack_clears", {30'd0, u_if.rx_valid, u_if.overrun}, 32'd0);

        // Pop coinciding with completion: completion edge is 609 clocks after busy rises
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        fork
            send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                n = 0;
                while (busy !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("coin_busy_seen", 32'(busy), 32'd1);
                repeat (608) @(posedge clk);
                @(negedge clk);
                chk("coin_pre_data", 32'(u_if.rx_data), 32'h11);
                chk("coin_pre_busy", 32'(busy), 32'd1);
                u_if.rx_ack = 1'b1;
                @(negedge clk);
                u_if.rx_ack = 1'b0;
                chk("coin_busy_done", 32'(busy), 32'd0);
                chk("coin_data", 32'(u_if.rx_data), 32'h22);
                chk("coin_valid", 32'(u_if.rx_valid), 32'd1);
                chk("coin_overrun", 32'(u_if.overrun), 32'd0);
            end
        join

        // en dropped mid-frame: abort, holding register keeps 0x22
        fork
            send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (200) @(negedge clk);
                en = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(busy), 32'd0);
            end
        join
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_hold_data", 32'(u_if.rx_data), 32'h22);
        chk("abort_hold_valid", 32'(u_if.rx_valid), 32'd1);
        chk("abort_hold_ovr", 32'(u_if.overrun), 32'd0);
        pop();

        // Reset during the data bits of 0x5A, then 0x81 is the only delivery
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (200) @(negedge clk);
                arst_n = 1'b0;
                @(negedge clk);
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_valid", 32'(u_if.rx_valid), 32'd0);
                repeat (500) @(negedge clk);
                arst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, u_if.rx_valid}, 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("r81_valid", 200);
        chk("r81_data", 32'(u_if.rx_data), 32'h81);
        chk("r81_flags", {29'd0, u_if.parity_err, u_if.frame_err, u_if.overrun}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_ip_rx.md
UART_IP_RX -- requirements
Module: uart_ip_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit period.
REQ-003 clk  input  1  system clock; one clock, all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 en  input  1  receiver active (control bit 0).
REQ-007 frame_sel  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 parity_sel  input  2  00/11=none, 01=even, 10=odd.
REQ-009 stop_sel  input  1  stop bits: 0=one, 1=two.
REQ-010 baud_sel  input  4  index into the 16-entry baud table (200 to 460800; 7=9600).
REQ-011 rx_data  output  8  received word, LSB-first assembly, unused upper bits zero.
REQ-012 rx_valid  output  1  holding register full; level, held until acknowledged.
REQ-013 rx_ack  input  1  consumer pop; clears rx_valid on the next edge.
REQ-014 parity_err, frame_err, overrun  output  1 each  sticky status for the held word.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 rx shall pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-017 Tick generator shall pulse once every DIV = CLK_FREQ_HZ/(OVERSAMPLE*BAUD[baud_sel]) clocks, using integer floor and a minimum of 1; DIV=651 at 100 MHz/9600.
REQ-018 The tick counter shall reload on falling-edge detection in IDLE, so the start bit is phase-aligned.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-020 IDLE->START on a synchronized 1->0 transition while en=1.
REQ-021 START: at tick OVERSAMPLE/2, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, nothing reported).
REQ-022 DATA shall sample every OVERSAMPLE ticks thereafter, shifting N=frame bits; after the Nth bit -> PARITY if parity enabled, else STOP1.
REQ-023 PARITY: even parity requires XOR(data,parity bit)=0; odd parity requires it to be 1; a mismatch sets the word's parity_err.
REQ-024 STOP1: sample=0 sets frame_err; -> STOP2 if stop_sel=1, else complete.
REQ-025 STOP2: sample=0 sets frame_err; then complete.
REQ-026 frame_sel, parity_sel, stop_sel and baud_sel shall be latched at IDLE->START; changes mid-frame shall have no effect until the next frame.
REQ-027 Complete: on the edge after the final stop sample, the FSM shall return to IDLE and load the word plus its errors into the holding register, asserting rx_valid.
REQ-028 A frame with frame_err shall still be delivered, with frame_err=1.
REQ-029 If the holding register is full without rx_ack in the completion cycle, the new word shall be discarded and overrun set; held data and errors are unchanged.
REQ-030 If rx_ack and completion coincide, the new word shall load, rx_valid stays 1, and overrun is not set.
REQ-031 rx_ack while rx_valid=0 shall be ignored; rx_ack shall clear rx_valid, parity_err, frame_err and overrun.
REQ-032 en deasserted mid-frame shall abort to IDLE on the next edge with no delivery; the holding register is unaffected.

Reset
REQ-033 While arst_n=0: FSM=IDLE, counters=0, synchronizer=1, rx_data=0, and rx_valid, parity_err, frame_err, overrun and busy all 0.
REQ-034 Reset asserted mid-frame shall discard the partial frame; after release, the receiver waits for a fresh falling edge.

Structure
REQ-035 Package uart_ip_pkg shall hold the BAUD_RATES table, the frame/parity/stop encodings, the FSM state enum, and a divider function.
REQ-036 One sub-module, uart_ip_baud_tick (divider plus resync input, tick output), shall be used; the bit FSM, shifter and holding register live in uart_ip_rx.

Verification (CLK_FREQ_HZ=100e6, baud_sel=7, en=1)
REQ-037 8N1 0xA5 -> rx_data=0xA5, rx_valid=1 about 10 bit times after the start edge, with no errors; rx_ack clears it.
REQ-038 frame_sel=00, even parity, data 0x15 with parity bit 0 -> rx_data=0x15, parity_err=1.
REQ-039 A low pulse of 3/16 bit -> busy rises then falls, and rx_valid stays 0.
REQ-040 8N2 0x3C with the second stop bit driven 0 -> rx_data=0x3C, frame_err=1.
REQ-041 Two frames 0x11 then 0x22 with no rx_ack -> rx_data=0x11, overrun=1; then rx_ack at the second completion -> rx_data=0x22 with overrun=0.
REQ-042 arst_n pulsed low during the DATA bits of 0x5A, then 0x81 sent -> only 0x81 is delivered.
